// File: rtl/dsp_mac_sequencer.sv
// ---------------------------------------------------------------------------
// dsp_mac_sequencer
//
// Upstream controller for a DSP48A1-style slice (DSP_TOP). Accepts a stream
// of signed 18x18 operand pairs, issues them into the slice as a
// multiply-accumulate sequence, and steers OPMODE so that the first product
// of each vector overwrites P (Z=0) and every later product adds onto P (Z=P).
// After the last pair it waits out the slice pipeline, captures P, and holds
// it on a valid/ready result port until accepted.
//
// Ports
//   CLK         clock, rising edge (also clocks DSP_TOP)
//   RSTN        asynchronous active-low reset
//   s_valid     operand pair valid
//   s_ready     sequencer can accept a pair
//   s_a, s_b    signed 18-bit multiplicand / multiplier
//   s_last      pair is the final one of the current vector
//   dsp_a/b     operands to DSP_TOP A / B (B_INPUT="DIRECT")
//   dsp_opmode  OPMODE to DSP_TOP, one cycle behind its operands
//   dsp_ce      clock enable for every DSP_TOP CE* input
//   dsp_p       P output of DSP_TOP
//   m_valid     result valid
//   m_ready     result accepted
//   m_data      accumulated 48-bit sum (wraps modulo 2^48)
//   m_count     number of beats in the vector, saturating at all-ones
// ---------------------------------------------------------------------------
module dsp_mac_sequencer #(
  parameter int PIPE_LAT = 3,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [17:0]      s_a,
  input  logic [17:0]      s_b,
  input  logic             s_last,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_ce,
  input  logic [47:0]      dsp_p,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [47:0]      m_data,
  output logic [CNT_W-1:0] m_count
);

  // X=M, Z=0 : start a fresh sum with this product
  localparam logic [7:0] OP_FIRST = 8'b0000_0001;
  // X=M, Z=P : add this product onto the running sum
  localparam logic [7:0] OP_ACC   = 8'b0000_1001;

  localparam int LAT_W = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t             state_reg,      state_next;
  logic               s_ready_reg,    s_ready_next;
  logic               dsp_ce_reg,     dsp_ce_next;
  logic [17:0]        dsp_a_reg,      dsp_a_next;
  logic [17:0]        dsp_b_reg,      dsp_b_next;
  logic [7:0]         dsp_opmode_reg, dsp_opmode_next;
  logic               first_reg,      first_next;
  logic [LAT_W-1:0]   lat_cnt_reg,    lat_cnt_next;
  logic               m_valid_reg,    m_valid_next;
  logic [47:0]        m_data_reg,     m_data_next;
  logic [CNT_W-1:0]   m_count_reg,    m_count_next;

  logic beat;

  // s_ready is registered, so a beat is judged against the value the
  // upstream source actually saw during this cycle.
  assign beat = s_valid & s_ready_reg;

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_reg      <= IDLE;
      s_ready_reg    <= 1'b0;
      dsp_ce_reg     <= 1'b0;
      dsp_a_reg      <= '0;
      dsp_b_reg      <= '0;
      dsp_opmode_reg <= '0;
      first_reg      <= 1'b0;
      lat_cnt_reg    <= '0;
      m_valid_reg    <= 1'b0;
      m_data_reg     <= '0;
      m_count_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      s_ready_reg    <= s_ready_next;
      dsp_ce_reg     <= dsp_ce_next;
      dsp_a_reg      <= dsp_a_next;
      dsp_b_reg      <= dsp_b_next;
      dsp_opmode_reg <= dsp_opmode_next;
      first_reg      <= first_next;
      lat_cnt_reg    <= lat_cnt_next;
      m_valid_reg    <= m_valid_next;
      m_data_reg     <= m_data_next;
      m_count_reg    <= m_count_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and next-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    // Operands default to zero: a bubble or drain slot multiplies 0*0, so
    // the ACC opcode leaves P unchanged.
    dsp_a_next   = '0;
    dsp_b_next   = '0;
    // first_reg is a one-cycle marker that follows the vector's first
    // operands; it becomes the FIRST opcode one cycle later, which lines the
    // opcode up with the product inside the slice pipeline.
    first_next      = 1'b0;
    dsp_opmode_next = first_reg ? OP_FIRST : OP_ACC;
    lat_cnt_next = lat_cnt_reg;
    m_valid_next = m_valid_reg;
    m_data_next  = m_data_reg;
    m_count_next = m_count_reg;

    unique case (state_reg)
      IDLE: begin
        if (beat) begin
          dsp_a_next   = s_a;
          dsp_b_next   = s_b;
          first_next   = 1'b1;
          m_count_next = CNT_W'(1);
          lat_cnt_next = '0;
          state_next   = s_last ? DRAIN : ACCUM;
        end
      end

      ACCUM: begin
        if (beat) begin
          dsp_a_next = s_a;
          dsp_b_next = s_b;
          // Beat count saturates; the sum keeps accumulating regardless.
          if (m_count_reg != {CNT_W{1'b1}}) begin
            m_count_next = m_count_reg + CNT_W'(1);
          end
          if (s_last) begin
            lat_cnt_next = '0;
            state_next   = DRAIN;
          end
        end
      end

      DRAIN: begin
        // The last operands reach P PIPE_LAT edges after they were loaded;
        // P is sampled on the edge after that.
        if (lat_cnt_reg == LAT_W'(PIPE_LAT)) begin
          m_data_next  = dsp_p;
          m_valid_next = 1'b1;
          state_next   = HOLD;
        end else begin
          lat_cnt_next = lat_cnt_reg + LAT_W'(1);
        end
      end

      HOLD: begin
        if (m_valid_reg && m_ready) begin
          m_valid_next = 1'b0;
          state_next   = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Handshake and clock-enable follow the state being entered, so they are
    // registered alongside it and read as zero while reset is asserted.
    s_ready_next = (state_next == IDLE) || (state_next == ACCUM);
    // The slice is frozen while idle and while a result is pending.
    dsp_ce_next  = (state_next == ACCUM) || (state_next == DRAIN);
  end

  assign s_ready    = s_ready_reg;
  assign dsp_ce     = dsp_ce_reg;
  assign dsp_a      = dsp_a_reg;
  assign dsp_b      = dsp_b_reg;
  assign dsp_opmode = dsp_opmode_reg;
  assign m_valid    = m_valid_reg;
  assign m_data     = m_data_reg;
  assign m_count    = m_count_reg;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
module tb_dsp_mac_sequencer;

  localparam int PIPE_LAT = 3;
  localparam int CNT_W    = 16;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [17:0]      s_a = '0;
  logic [17:0]      s_b = '0;
  logic             s_last = 1'b0;
  logic [17:0]      dsp_a;
  logic [17:0]      dsp_b;
  logic [7:0]       dsp_opmode;
  logic             dsp_ce;
  logic [47:0]      dsp_p;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [47:0]      m_data;
  logic [CNT_W-1:0] m_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;

  // Operand tables for the vector currently being sent
  logic signed [17:0] va [64];
  logic signed [17:0] vb [64];

  dsp_mac_sequencer #(.PIPE_LAT(PIPE_LAT), .CNT_W(CNT_W)) dut (
    .CLK        (clk),
    .RSTN       (rstn),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_a        (s_a),
    .s_b        (s_b),
    .s_last     (s_last),
    .dsp_a      (dsp_a),
    .dsp_b      (dsp_b),
    .dsp_opmode (dsp_opmode),
    .dsp_ce     (dsp_ce),
    .dsp_p      (dsp_p),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_count    (m_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slice model: A1/B1 regs, M reg, OPMODE reg, P reg, all on one CE.
  // It is not reset with the sequencer, so stale contents survive RSTN.
  logic signed [17:0] a1_q = '0;
  logic signed [17:0] b1_q = '0;
  logic signed [35:0] m_q  = '0;
  logic [7:0]         op_q = '0;
  logic [47:0]        p_q  = '0;
  logic [47:0]        x_mux;
  logic [47:0]        z_mux;
  assign x_mux = (op_q[1:0] == 2'b01) ? {{12{m_q[35]}}, m_q} : 48'd0;
  assign z_mux = (op_q[3:2] == 2'b10) ? p_q : 48'd0;
  assign dsp_p = p_q;
  always @(posedge clk) begin
    if (dsp_ce) begin
      a1_q <= dsp_a;
      b1_q <= dsp_b;
      m_q  <= 36'(a1_q) * 36'(b1_q);
      op_q <= dsp_opmode;
      p_q  <= z_mux + x_mux;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: dot product of the first n table entries, modulo 2^48
  function automatic logic [47:0] ref_sum(input int n);
    longint s;
    s = 0;
    for (int i = 0; i < n; i++) s += longint'(va[i]) * longint'(vb[i]);
    return s[47:0];
  endfunction

  function automatic logic [CNT_W-1:0] ref_count(input int n);
    return (n > 65535) ? 16'hFFFF : 16'(n);
  endfunction

  // Sends n pairs with 'bubbles' idle cycles between them; entered and left
  // just after a falling edge. last_acc records the edge that took s_last.
  task automatic send_vector(input int n, input int bubbles);
    int waited;
    for (int i = 0; i < n; i++) begin
      if (i > 0 && bubbles > 0) begin
        s_valid = 1'b0;
        repeat (bubbles) @(negedge clk);
      end
      s_valid = 1'b1;
      s_a     = va[i];
      s_b     = vb[i];
      s_last  = (i == n - 1);
      waited  = 0;
      while (!s_ready && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 50) check("accept_timeout", 64'(s_ready), 64'd1);
      last_acc = cyc + 1;
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_a     = '0;
    s_b     = '0;
  endtask

  task automatic wait_result(input string tag, input int n);
    int k;
    k = 0;
    while (!m_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_m_valid"}, 64'(m_valid), 64'd1);
    check({tag, "_latency"}, 64'(cyc - last_acc), 64'(PIPE_LAT + 1));
    check({tag, "_m_data"}, 64'(m_data), 64'(ref_sum(n)));
    check({tag, "_m_count"}, 64'(m_count), 64'(ref_count(n)));
    check({tag, "_s_ready_hold"}, 64'(s_ready), 64'd0);
    check({tag, "_ce_hold"}, 64'(dsp_ce), 64'd0);
  endtask

  task automatic ack(input string tag, input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_held_valid"}, 64'(m_valid), 64'd1);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check({tag, "_valid_cleared"}, 64'(m_valid), 64'd0);
    check({tag, "_s_ready_back"}, 64'(s_ready), 64'd1);
  endtask

  initial begin
    logic [47:0] held;
    int hs;
    int n;
    int bub;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_dsp_ce", 64'(dsp_ce), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_m_count", 64'(m_count), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_s_ready", 64'(s_ready), 64'd1);

    // Dot product, back-to-back
    va[0] = 18'd20; vb[0] = 18'd10;
    va[1] = 18'd5;  vb[1] = 18'd6;
    va[2] = 18'd3;  vb[2] = 18'd3;
    va[3] = 18'd1;  vb[3] = 18'd1;
    send_vector(4, 0);
    wait_result("dot", 4);
    check("dot_value", 64'(m_data), 64'hF0);
    ack("dot", 0);

    // Same pairs with two bubbles between beats
    send_vector(4, 2);
    wait_result("bubble", 4);
    check("bubble_value", 64'(m_data), 64'hF0);
    ack("bubble", 0);

    // Signed operands
    va[0] = 18'h3FFFE; vb[0] = 18'd3;
    va[1] = 18'h3FFFF; vb[1] = 18'h3FFFF;
    send_vector(2, 0);
    wait_result("signed", 2);
    check("signed_value", 64'(m_data), 64'hFFFF_FFFF_FFFB);
    ack("signed", 0);

    // Back-to-back single-beat vectors
    va[0] = 18'd7; vb[0] = 18'd7;
    send_vector(1, 0);
    wait_result("b2b_first", 1);
    check("b2b_first_value", 64'(m_data), 64'd49);
    ack("b2b_first", 0);
    va[0] = 18'd1; vb[0] = 18'd2;
    send_vector(1, 0);
    wait_result("b2b_second", 1);
    check("b2b_second_value", 64'(m_data), 64'd2);
    ack("b2b_second", 0);

    // Backpressure with a new vector queued behind the pending result
    va[0] = 18'd3; vb[0] = 18'd4;
    send_vector(1, 0);
    wait_result("bp", 1);
    held    = m_data;
    s_valid = 1'b1;
    s_a     = 18'd5;
    s_b     = 18'd6;
    s_last  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("bp_m_valid_held", 64'(m_valid), 64'd1);
      check("bp_m_data_stable", 64'(m_data), 64'(held));
      check("bp_s_ready_low", 64'(s_ready), 64'd0);
    end
    m_ready = 1'b1;
    hs = cyc + 1;
    @(negedge clk);
    m_ready = 1'b0;
    check("bp_valid_cleared", 64'(m_valid), 64'd0);
    check("bp_s_ready_after_hs", 64'(s_ready), 64'd1);
    last_acc = hs + 1;
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("bp_queued_operand", 64'(dsp_a), 64'd5);
    va[0] = 18'd5; vb[0] = 18'd6;
    wait_result("bp_queued", 1);
    ack("bp_queued", 0);

    // Reset mid-ACCUM with s_valid held high
    s_valid = 1'b1;
    s_a     = 18'd9;
    s_b     = 18'd9;
    s_last  = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_state_ce", 64'(dsp_ce), 64'd1);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_s_ready", 64'(s_ready), 64'd0);
    check("mid_rst_m_valid", 64'(m_valid), 64'd0);
    check("mid_rst_dsp_ce", 64'(dsp_ce), 64'd0);
    check("mid_rst_dsp_a", 64'(dsp_a), 64'd0);
    check("mid_rst_dsp_b", 64'(dsp_b), 64'd0);
    check("mid_rst_opmode", 64'(dsp_opmode), 64'd0);
    check("mid_rst_m_data", 64'(m_data), 64'd0);
    check("mid_rst_m_count", 64'(m_count), 64'd0);
    @(negedge clk);
    s_valid = 1'b0;
    rstn    = 1'b1;
    @(negedge clk);
    va[0] = 18'd2; vb[0] = 18'd3;
    send_vector(1, 0);
    check("single_dsp_a", 64'(dsp_a), 64'd2);
    check("single_dsp_b", 64'(dsp_b), 64'd3);
    @(negedge clk);
    check("single_opmode_first", 64'(dsp_opmode), 64'h01);
    check("single_drain_a", 64'(dsp_a), 64'd0);
    check("single_drain_s_ready", 64'(s_ready), 64'd0);
    @(negedge clk);
    check("single_opmode_acc", 64'(dsp_opmode), 64'h09);
    wait_result("after_rst", 1);
    check("after_rst_value", 64'(m_data), 64'd6);
    ack("after_rst", 0);

    // Randomized vectors against the reference
    for (int v = 0; v < 12; v++) begin
      n   = $urandom_range(1, 8);
      bub = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) begin
        va[i] = 18'($urandom);
        vb[i] = 18'($urandom);
      end
      send_vector(n, bub);
      wait_result("rand", n);
      ack("rand", $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
